// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts the ones in a stochastic bitstream over a window of
// 2^WIDTH cycles. It then offers the result on a valid/ready style output.
// The FSM has three states: IDLE waits for start, COUNT takes the samples, and
// HOLD keeps the result until the consumer takes it.
// Optional build macro SC_DEC_BIPOLAR_EN: when defined, the result is reported
// as 2*ones - 2^WIDTH in two's complement. When undefined, the raw ones count
// is reported, zero-extended.
module sc_stream_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stream_in,
  input  logic             out_ready,
  output logic             busy,
  output logic [WIDTH+1:0] value,
  output logic             value_valid
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_LAST    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH:0]   ONES_ZERO   = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH+1:0] VALUE_ZERO  = {(WIDTH+2){1'b0}};
  localparam logic [WIDTH+1:0] WINDOW_SIZE = {2'b01, {WIDTH{1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   ones_q, ones_d;
  logic [WIDTH+1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH:0]   ones_inc_s;

  // Map a raw ones count to the reported encoding.
  // Both branches produce a result of WIDTH+2 bits.
  function automatic logic [WIDTH+1:0] convert_count(input logic [WIDTH:0] ones);
    logic [WIDTH+1:0] twice;
    twice = {ones, 1'b0};
`ifdef SC_DEC_BIPOLAR_EN
    // Subtracting modulo 2^(WIDTH+2) gives the two's complement result directly.
    return twice - WINDOW_SIZE;
`else
    return {1'b0, ones} | (twice & VALUE_ZERO);
`endif
  endfunction

  // Ones count including the current sample. The counter is WIDTH+1 bits, so
  // it cannot wrap even when all 2^WIDTH samples are ones.
  assign ones_inc_s = ones_q + {{WIDTH{1'b0}}, stream_in};

  // Next-state and datapath updates for the IDLE/COUNT/HOLD sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    value_d = value_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COUNT;
          cnt_d   = CNT_ZERO;
          ones_d  = ONES_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        // start is deliberately ignored while a window is being counted.
        ones_d = ones_inc_s;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_HOLD;
          value_d = convert_count(ones_inc_s);
          valid_d = 1'b1;
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (start) begin
            // The handshake completes and a new window starts with no idle gap.
            state_d = ST_COUNT;
            cnt_d   = CNT_ZERO;
            ones_d  = ONES_ZERO;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_COUNT);
  end

  // State and output registers; a synchronous reset discards any partial window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      ones_q  <= ONES_ZERO;
      value_q <= VALUE_ZERO;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      value_q <= value_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign value       = value_q;
  assign value_valid = valid_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder with WIDTH=4 (16-sample windows).
// Expected results come from a queue of the applied samples and from plain
// arithmetic on the number of ones in that queue.
module tb_sc_stream_decoder;

  localparam int W = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stream_in;
  logic         out_ready;
  logic         busy;
  logic [W+1:0] value;
  logic         value_valid;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W+1:0] last_value;

  sc_stream_decoder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stream_in  (stream_in),
    .out_ready  (out_ready),
    .busy       (busy),
    .value      (value),
    .value_valid(value_valid)
  );

  // Free-running clock with a 10 time-unit period.
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance one clock edge, then settle before the outputs are looked at.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result for a window that contained the given number of ones.
  function automatic logic [W+1:0] ref_value(input int ones);
    int v;
    v = ones;
`ifdef SC_DEC_BIPOLAR_EN
    v = 2 * ones - N;
`endif
    return v[W+1:0];
  endfunction

  // Raise start for one cycle while the DUT is in IDLE.
  task automatic accept_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive one full window and check the result.
  // mode 0: all ones; 1: 1,0,1,0...; 2: all zeros; 3: random with p(1)=0.75.
  // start is toggled at random during the window because the DUT must ignore it.
  task automatic sample_window(input int mode, input string tag);
    bit samples[$];
    bit b;
    int ones;
    samples.delete();
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       b = 1'b1;
        1:       b = (i % 2 == 0);
        2:       b = 1'b0;
        3:       b = ($urandom_range(3, 0) != 0);
        default: b = 1'b0;
      endcase
      stream_in = b;
      start     = ($urandom_range(1, 0) == 1);
      samples.push_back(b);
      check_eq({tag, "_busy_during"}, {31'd0, busy}, 32'd1);
      check_eq({tag, "_valid_during"}, {31'd0, value_valid}, 32'd0);
      tick();
    end
    start = 1'b0;
    ones  = 0;
    foreach (samples[k]) ones += int'(samples[k]);
    last_value = ref_value(ones);
    check_eq({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_valid_done"}, {31'd0, value_valid}, 32'd1);
    check_eq({tag, "_value"}, {26'd0, value}, {26'd0, last_value});
  endtask

  // Complete the output handshake, optionally starting the next window at once.
  task automatic release_hold(input bit restart, input string tag);
    out_ready = 1'b1;
    start     = restart;
    stream_in = $urandom_range(1, 0);
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check_eq({tag, "_valid_rel"}, {31'd0, value_valid}, 32'd0);
    check_eq({tag, "_busy_rel"}, {31'd0, busy}, {31'd0, restart});
    check_eq({tag, "_value_rel"}, {26'd0, value}, {26'd0, last_value});
  endtask

  // Main stimulus sequence.
  initial begin
    bit restart;
    rst        = 1'b1;
    start      = 1'b0;
    stream_in  = 1'b0;
    out_ready  = 1'b0;
    last_value = '0;
    tick();
    tick();
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_valid", {31'd0, value_valid}, 32'd0);
    check_eq("rst_value", {26'd0, value}, 32'd0);
    rst = 1'b0;

    // All-ones window: the counter must reach exactly 16 without wrapping.
    accept_start();
    sample_window(0, "ones");

    // Hold for 5 cycles: value stays constant; start and stream_in are ignored.
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      start     = $urandom_range(1, 0);
      stream_in = $urandom_range(1, 0);
      tick();
      check_eq("hold_valid", {31'd0, value_valid}, 32'd1);
      check_eq("hold_value", {26'd0, value}, {26'd0, last_value});
      check_eq("hold_busy", {31'd0, busy}, 32'd0);
    end
    start = 1'b0;
    release_hold(1'b0, "ones");

    // Alternating window, then a back-to-back handshake into an all-zeros window.
    accept_start();
    sample_window(1, "toggle");
    release_hold(1'b1, "b2b");
    sample_window(2, "zeros");
    release_hold(1'b0, "zeros");

    // start is re-pulsed at sample 5 and reset is applied at sample 9.
    accept_start();
    for (int i = 0; i < 8; i++) begin
      start     = (i == 4);
      stream_in = 1'b1;
      tick();
      check_eq("intr_busy", {31'd0, busy}, 32'd1);
      check_eq("intr_valid", {31'd0, value_valid}, 32'd0);
    end
    start     = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    check_eq("intr_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("intr_rst_valid", {31'd0, value_valid}, 32'd0);
    check_eq("intr_rst_value", {26'd0, value}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      stream_in = $urandom_range(1, 0);
      tick();
      check_eq("idle_busy", {31'd0, busy}, 32'd0);
      check_eq("idle_valid", {31'd0, value_valid}, 32'd0);
    end
    accept_start();
    sample_window(0, "fresh");
    release_hold(1'b0, "fresh");

    // Four random windows with p=0.75, random hold times and random restarts.
    accept_start();
    for (int k = 0; k < 4; k++) begin
      sample_window(3, "rand");
      for (int d = 0; d < int'($urandom_range(3, 0)); d++) begin
        tick();
        check_eq("rand_hold_valid", {31'd0, value_valid}, 32'd1);
        check_eq("rand_hold_value", {26'd0, value}, {26'd0, last_value});
      end
      restart = (k < 3) && ($urandom_range(1, 0) == 1);
      release_hold(restart, "rand");
      if (!restart && k < 3) accept_start();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
